// File: rtl/timer_arb_pkg.sv
// ============================================================================
// timer_arb_pkg : shared state encoding, default width and grant helper
// Rev 1.0
// ============================================================================
`default_nettype none

package timer_arb_pkg;

    localparam int C_DEFAULT_N = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

`default_nettype wire

// File: rtl/timer_arb_load_counter.sv
// ============================================================================
// load_counter : N-bit up-counter with priority load and terminal-count carry
// Rev 1.0
// ============================================================================
`default_nettype none

module load_counter
    import timer_arb_pkg::*;
#(
    parameter int N = C_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [N-1:0] din,
    output logic [N-1:0] q,
    output logic         cout
);

    logic [N-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= din;
        end else if (en) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q    = r_q;
    assign cout = en & (&r_q);

endmodule

`default_nettype wire

// File: rtl/timer_arb.sv
// ============================================================================
// timer_arb : two-requester round-robin arbiter sharing one delay counter
// Rev 1.0
// ============================================================================
`default_nettype none

module timer_arb
    import timer_arb_pkg::*;
#(
    parameter int N = C_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req,
    input  logic [N-1:0] delay0,
    input  logic [N-1:0] delay1,
    output logic [1:0]   gnt,
    output logic [1:0]   done,
    output logic         busy,
    output logic [N-1:0] cnt
);

    state_t       r_state;
    state_t       w_state_next;
    logic         r_owner;
    logic         r_ptr;
    logic [1:0]   r_gnt;
    logic [1:0]   r_done;
    logic [1:0]   w_gnt_next;
    logic [1:0]   w_done_next;
    logic         w_winner;
    logic         w_owner_req;
    logic         w_load;
    logic         w_en;
    logic         w_cout;
    logic         w_release;
    logic [N-1:0] w_delay;
    logic [N-1:0] w_din;

    // Ties go to the pointer side; otherwise the lone requester wins.
    assign w_winner    = (&req) ? r_ptr : ~req[0];
    assign w_delay     = w_winner ? delay1 : delay0;
    // Two's-complement preload: D cycles to wrap, and D=0 gives a full 2^N.
    assign w_din       = {N{1'b0}} - w_delay;
    assign w_owner_req = req[r_owner];
    assign w_load      = (r_state == IDLE) && (|req);
    assign w_en        = (r_state == COUNT) && w_owner_req;
    // Ownership ends either by completion or by abort.
    assign w_release   = (r_state == DONE) || ((r_state == COUNT) && !w_owner_req);

    load_counter #(.N(N)) u_counter (
        .clk  (clk),
        .rst  (rst),
        .en   (w_en),
        .load (w_load),
        .din  (w_din),
        .q    (cnt),
        .cout (w_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (|req) w_state_next = COUNT;
            COUNT: begin
                if (!w_owner_req) begin
                    w_state_next = IDLE;
                end else if (w_cout) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_gnt_next  = 2'b00;
        w_done_next = 2'b00;
        case (r_state)
            IDLE: begin
                if (|req) w_gnt_next = onehot2(w_winner);
            end
            COUNT: begin
                if (w_owner_req) begin
                    w_gnt_next = onehot2(r_owner);
                    if (w_cout) w_done_next = onehot2(r_owner);
                end
            end
            default: begin
                w_gnt_next  = 2'b00;
                w_done_next = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= 1'b0;
            r_ptr   <= 1'b0;
            r_gnt   <= 2'b00;
            r_done  <= 2'b00;
        end else begin
            r_gnt  <= w_gnt_next;
            r_done <= w_done_next;
            if (w_load) begin
                r_owner <= w_winner;
            end
            if (w_release) begin
                r_ptr <= ~r_owner;
            end
        end
    end

    assign gnt  = r_gnt;
    assign done = r_done;
    assign busy = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_timer_arb.sv
// ============================================================================
// tb_timer_arb : directed and randomized checks of timer_arb vs a job-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_timer_arb;

    localparam int N = 10;
    localparam int M = 1 << N;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [1:0]   req = 2'b00;
    logic [N-1:0] delay0 = '0;
    logic [N-1:0] delay1 = '0;
    logic [1:0]   gnt;
    logic [1:0]   done;
    logic         busy;
    logic [N-1:0] cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    timer_arb #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .delay0 (delay0),
        .delay1 (delay1),
        .gnt    (gnt),
        .done   (done),
        .busy   (busy),
        .cnt    (cnt)
    );

    // Job-level model: who owns the counter, cycles left, and the visible count.
    bit m_busy, m_done_ph;
    int m_owner, m_ptr, m_remain, m_cnt;

    function automatic void model_reset();
        m_busy = 0; m_done_ph = 0; m_owner = 0; m_ptr = 0; m_remain = 0; m_cnt = 0;
    endfunction

    task automatic model_edge();
        int w, d;
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            if (req != 2'b00) begin
                w = (req == 2'b11) ? m_ptr : (req[0] ? 0 : 1);
                d = (w == 1) ? int'(delay1) : int'(delay0);
                m_owner = w;
                m_remain = (d == 0) ? M : d;
                m_cnt = (M - d) % M;
                m_busy = 1;
            end
        end else if (!m_done_ph) begin
            if (!req[m_owner]) begin
                m_busy = 0;
                m_ptr = 1 - m_owner;
            end else begin
                m_cnt = (m_cnt + 1) % M;
                m_remain--;
                if (m_remain == 0) m_done_ph = 1;
            end
        end else begin
            m_busy = 0;
            m_done_ph = 0;
            m_ptr = 1 - m_owner;
        end
    endtask

    function automatic logic [N+4:0] exp_vec();
        logic [1:0] g;
        g = m_busy ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
        return {g, (m_done_ph ? g : 2'b00), m_busy, N'(m_cnt)};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({gnt, done, busy, cnt} !== '0)
            $display("FAIL reset_async got gnt=%b done=%b busy=%b cnt=%0d want all 0", gnt, done, busy, cnt);
        else n_pass++;
        tick();
        rst = 1'b0;
        req = 2'b00;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if ({gnt, done, busy, cnt} !== '0 || {gnt, done, busy, cnt} !== exp_vec())
                $display("FAIL reset_idle cyc=%0d got gnt=%b done=%b busy=%b cnt=%0d want all 0", i, gnt, done, busy, cnt);
            else n_pass++;
        end
    endtask

    task automatic test_single();
        int done_cyc = -1, n_done = 0;
        apply_reset();
        req = 2'b01;
        delay0 = N'(5);
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (i == 1) begin
                n_checks++;
                if (gnt !== 2'b01 || cnt !== N'(1019) || busy !== 1'b1)
                    $display("FAIL single_grant got gnt=%b cnt=%0d busy=%b want gnt=01 cnt=1019 busy=1", gnt, cnt, busy);
                else n_pass++;
            end
            if (done !== 2'b00) begin n_done++; done_cyc = i; end
            if (i == 6) req = 2'b00;
            n_checks++;
            if ({gnt, done, busy, cnt} !== exp_vec())
                $display("FAIL single cyc=%0d got %h want %h", i, {gnt, done, busy, cnt}, exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (n_done != 1 || done_cyc != 6)
            $display("FAIL single_done got pulses=%0d at=%0d want pulses=1 at=6", n_done, done_cyc);
        else n_pass++;
    endtask

    task automatic test_contention();
        int t_done[$];
        int o_done[$];
        apply_reset();
        req = 2'b11;
        delay0 = N'(3);
        delay1 = N'(4);
        for (int i = 1; i <= 26; i++) begin
            tick();
            if (done !== 2'b00) begin t_done.push_back(i); o_done.push_back(done[1] ? 1 : 0); end
            n_checks++;
            if ({gnt, done, busy, cnt} !== exp_vec())
                $display("FAIL contention cyc=%0d got %h want %h", i, {gnt, done, busy, cnt}, exp_vec());
            else n_pass++;
        end
        req = 2'b00;
        n_checks++;
        if (t_done.size() < 4)
            $display("FAIL contention_count got %0d done pulses want >=4", t_done.size());
        else begin
            n_pass++;
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (o_done[k] != (k % 2) || (k > 0 && t_done[k] - t_done[k-1] != ((k % 2) ? 6 : 5)))
                    $display("FAIL contention_seq k=%0d got owner=%0d at=%0d want owner=%0d", k, o_done[k], t_done[k], k % 2);
                else n_pass++;
            end
        end
        tick();
        tick();
    endtask

    task automatic test_abort();
        logic [N-1:0] frozen;
        apply_reset();
        req = 2'b10;
        delay1 = N'(20);
        for (int i = 0; i < 6; i++) tick();
        frozen = cnt;
        req = 2'b00;
        delay1 = N'(7);
        tick();
        n_checks++;
        if (gnt !== 2'b00 || done !== 2'b00 || busy !== 1'b0 || cnt !== frozen || cnt !== N'(1009))
            $display("FAIL abort got gnt=%b done=%b busy=%b cnt=%0d want 00 00 0 cnt=1009", gnt, done, busy, cnt);
        else n_pass++;
        req = 2'b11;
        tick();
        n_checks++;
        if (gnt !== 2'b01 || {gnt, done, busy, cnt} !== exp_vec())
            $display("FAIL abort_next got gnt=%b cnt=%0d want gnt=01 (model %h)", gnt, cnt, exp_vec());
        else n_pass++;
        req = 2'b00;
        tick();
    endtask

    task automatic test_boundary();
        int n_count = 0;
        bit seen = 0;
        apply_reset();
        req = 2'b01;
        delay0 = N'(1);
        tick();
        n_checks++;
        if (gnt !== 2'b01 || cnt !== N'(1023) || done !== 2'b00)
            $display("FAIL d1_count got gnt=%b cnt=%0d done=%b want 01 1023 00", gnt, cnt, done);
        else n_pass++;
        req = 2'b01;
        tick();
        req = 2'b00;
        n_checks++;
        if (done !== 2'b01 || gnt !== 2'b01 || cnt !== '0)
            $display("FAIL d1_done got done=%b gnt=%b cnt=%0d want 01 01 0", done, gnt, cnt);
        else n_pass++;
        tick();
        req = 2'b01;
        delay0 = '0;
        tick();
        while (!seen && n_count < 1100) begin
            tick();
            n_count++;
            if (done !== 2'b00) seen = 1;
        end
        req = 2'b00;
        n_checks++;
        if (!seen || n_count != 1024 || {gnt, done, busy, cnt} !== exp_vec())
            $display("FAIL d0_len got seen=%0d cycles=%0d want done after 1024 COUNT cycles", seen, n_count);
        else n_pass++;
        tick();
    endtask

    task automatic test_async_reset();
        bit saw_done = 0;
        apply_reset();
        req = 2'b10;
        delay1 = N'(50);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done !== 2'b00) saw_done = 1;
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({gnt, done, busy, cnt} !== '0 || saw_done)
            $display("FAIL async_rst got gnt=%b done=%b busy=%b cnt=%0d saw_done=%0d want all 0", gnt, done, busy, cnt, saw_done);
        else n_pass++;
        tick();
        rst = 1'b0;
        req = 2'b11;
        delay0 = N'(2);
        tick();
        n_checks++;
        if (gnt !== 2'b01 || {gnt, done, busy, cnt} !== exp_vec())
            $display("FAIL async_rst_ptr got gnt=%b want 01", gnt);
        else n_pass++;
        req = 2'b00;
        tick();
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) req = 2'($urandom_range(0, 3));
            delay0 = ($urandom_range(0, 60) == 0) ? '0 : N'($urandom_range(1, 12));
            delay1 = ($urandom_range(0, 60) == 0) ? '0 : N'($urandom_range(1, 12));
            tick();
            n_checks++;
            if ({gnt, done, busy, cnt} !== exp_vec())
                $display("FAIL random cyc=%0d req=%b got %h want %h", i, req, {gnt, done, busy, cnt}, exp_vec());
            else n_pass++;
        end
        req = 2'b00;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_abort();
        test_boundary();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/timer_arb.md
TIMER_ARB -- requirements
Module: timer_arb

Interface
REQ-001 SHALL have parameter N, default 10, the counter/delay width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port req, input, 2 bits: level request per requester (bit 0 = requester 0).
REQ-005 SHALL have port delay0, input, N bits: requester 0 delay in cycles, sampled only at grant.
REQ-006 SHALL have port delay1, input, N bits: requester 1 delay in cycles, sampled only at grant.
REQ-007 SHALL have port gnt, output, 2 bits: registered one-hot grant, high while the owner's timing is in progress.
REQ-008 SHALL have port done, output, 2 bits: registered one-cycle completion pulse to the granted requester.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the FSM state is not IDLE.
REQ-010 SHALL have port cnt, output, N bits: current value of the shared counter.

Function
REQ-011 SHALL share one loadable N-bit up-counter between two requesters, using FSM states IDLE, COUNT and DONE.
REQ-012 In IDLE with no req bit set, the block SHALL hold: counter unchanged, gnt=0, done=0.
REQ-013 In IDLE with any req bit set, the block SHALL select the winner at the next edge, with the round-robin pointer side winning ties, and then:
- load the counter with (2^N - D) mod 2^N, where D is the winner's delay;
- set gnt[winner]=1;
- enter COUNT.
REQ-014 In COUNT, the counter SHALL increment by 1 every cycle.
REQ-015 In COUNT, at the edge where the counter equals all-ones, the counter SHALL wrap to 0 and the FSM SHALL enter DONE, so COUNT lasts exactly D cycles.
REQ-016 D=0 SHALL be treated as 2^N, so COUNT lasts 2^N cycles.
REQ-017 In DONE, for exactly one cycle, the block SHALL hold done[owner]=1 and gnt[owner]=1.
REQ-018 At the edge leaving DONE, the block SHALL clear gnt, set the pointer to the other requester and return to IDLE.
REQ-019 If req[owner] deasserts during COUNT, the block SHALL abort at the next edge: go to IDLE, clear gnt, produce no done pulse and advance the pointer to the other requester; cnt freezes at its current value.
REQ-020 The non-owner's req SHALL be ignored until IDLE, and its delay SHALL not be sampled before its grant.
REQ-021 A requester holding req through DONE SHALL re-compete in the following IDLE cycle; the pointer then favours the other side, guaranteeing alternation under contention.
REQ-022 Arbitration SHALL have exactly one IDLE bubble cycle between jobs, giving per-job occupancy of D+2 cycles.
REQ-023 delay0/delay1 changes after the grant edge SHALL have no effect on the running job.

Reset
REQ-024 On rst=1, asynchronously: state=IDLE, cnt=0, gnt=0, done=0, busy=0, pointer=requester 0.
REQ-025 rst asserted mid-COUNT or in DONE SHALL discard the job with no done pulse.
REQ-026 The first arbitration after rst deasserts SHALL occur at the first rising edge with rst low.

Structure
REQ-027 A shared package timer_arb_pkg SHALL hold the state enumeration (IDLE, COUNT, DONE) and the default width constant (10).
REQ-028 The counter SHALL be a separate sub-module, load_counter, with the following ports and behaviour:
- ports clk, rst, en, load, din[N-1:0], q[N-1:0], cout;
- load has priority over en;
- cout = en AND q all-ones.
REQ-029 The FSM, round-robin pointer and output registers SHALL reside in timer_arb.

Verification
REQ-030 Reset/idle: rst pulse, req=00 for 10 cycles -> gnt=00, done=00, busy=0, cnt=0 throughout.
REQ-031 Single job: req=01, delay0=5 -> gnt=01 from edge 1; cnt runs 1019..1023 over 5 COUNT cycles; done=01 for 1 cycle; busy falls after that cycle.
REQ-032 Contention: req=11 held, delay0=3, delay1=4 -> grants alternate 0,1,0,1 with done pulses 5 and 6 cycles apart (D+2).
REQ-033 Abort: req=10, delay1=20; drop req[1] after 6 COUNT cycles -> IDLE next edge, no done, next contention grants requester 0.
REQ-034 Boundaries:
- delay0=1 -> COUNT lasts 1 cycle, cnt=1023;
- delay0=0 -> done after exactly 1024 COUNT cycles.
REQ-035 Async reset mid-COUNT (delay1=50, rst at cycle 10) -> outputs 0 immediately without waiting for clk, no done pulse, pointer=0.
